y86_mem_bridge: RTL

Y86_MEM_BRIDGE -- requirements
Module: y86_mem_bridge

---
 rtl/y86_pkg.sv | 26 ++
 rtl/y86_mem_bridge_if.sv | 30 +++
 rtl/y86_byte_align.sv | 51 +++++
 rtl/y86_mem_bridge.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86 memory bridge.
// Holds the bridge FSM state encoding, the byte-align direction select,
// the word/byte width constants and the read value returned on a timeout.
package y86_pkg;

   localparam int WORD_W  = 32;
   localparam int BYTE_W  = 8;
   localparam int WADDR_W = 30;

   // Read data handed back to the core when a beat never gets mem_ack.
   localparam logic [WORD_W-1:0] TIMEOUT_RDATA = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ALIGN_WR_LO = 2'd0,
      ALIGN_WR_HI = 2'd1,
      ALIGN_RD    = 2'd2
   } align_dir_t;

endpackage

// File: rtl/y86_mem_bridge_if.sv
// Word-addressed memory beat bus between the bridge and the memory.
//   mem_addr  : word address of the beat
//   mem_req   : beat request, held until mem_ack
//   mem_we    : beat is a write
//   mem_be    : byte enables
//   mem_wdata : beat write data
//   mem_rdata : beat read data, valid with mem_ack
//   mem_ack   : beat complete
// master = bridge side, slave = memory side.
interface y86_mem_bridge_if;
   import y86_pkg::*;

   logic [WADDR_W-1:0] mem_addr;
   logic               mem_req;
   logic               mem_we;
   logic [3:0]         mem_be;
   logic [WORD_W-1:0]  mem_wdata;
   logic [WORD_W-1:0]  mem_rdata;
   logic               mem_ack;

   modport master (
      output mem_addr, mem_req, mem_we, mem_be, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_addr, mem_req, mem_we, mem_be, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/y86_byte_align.sv
// Combinational byte shifter/merger for unaligned accesses.
//   off_i     : byte offset within the word
//   dir_i     : ALIGN_WR_LO = first write beat, ALIGN_WR_HI = second write
//               beat, ALIGN_RD = merge two read beats into the result
//   data_lo_i : write data (write dirs) or first read beat (ALIGN_RD)
//   data_hi_i : second read beat (ALIGN_RD only)
//   data_o    : shifted / merged data
//   be_o      : byte enables for the beat
module y86_byte_align
   import y86_pkg::*;
(
   input  logic [1:0]        off_i,
   input  align_dir_t        dir_i,
   input  logic [WORD_W-1:0] data_lo_i,
   input  logic [WORD_W-1:0] data_hi_i,
   output logic [WORD_W-1:0] data_o,
   output logic [3:0]        be_o
);

   logic [5:0]          sh_lo;
   logic [5:0]          sh_hi;
   logic [2*WORD_W-1:0] pair_sh;

   always_comb begin
      sh_lo   = 6'(BYTE_W) * {4'b0000, off_i};
      // off=0 gives a 32-bit shift, i.e. an empty second beat.
      sh_hi   = 6'(WORD_W) - sh_lo;
      pair_sh = {data_hi_i, data_lo_i} >> sh_lo;
      data_o  = '0;
      be_o    = '0;
      case (dir_i)
         ALIGN_WR_LO: begin
            data_o = data_lo_i << sh_lo;
            be_o   = 4'hF << off_i;
         end
         ALIGN_WR_HI: begin
            data_o = data_lo_i >> sh_hi;
            be_o   = 4'hF >> (3'd4 - {1'b0, off_i});
         end
         ALIGN_RD: begin
            data_o = pair_sh[WORD_W-1:0];
            be_o   = 4'hF;
         end
         default: begin
            data_o = '0;
            be_o   = '0;
         end
      endcase
   end

endmodule

// File: rtl/y86_mem_bridge.sv
// Y86 core to word-memory bridge. Splits a byte-addressed 32-bit access into
// one (aligned) or two (unaligned) word beats, stalls the core meanwhile and
// returns little-endian read data for one cycle in DONE.
//   clk, rst            : clock, synchronous active-low reset
//   cpu_addr/re/we/wdata: core request
//   cpu_rdata           : read result, valid only in DONE
//   cpu_stall           : core freeze
//   bus_err             : sticky error (re+we together, or beat timeout)
//   mem                 : memory beat bus (master side)
//
// state | meaning
// IDLE  | waiting for a request; request is latched and BEAT0 issued
// BEAT0 | first word beat outstanding (word w)
// BEAT1 | second word beat outstanding (word w+1), unaligned only
// DONE  | result presented for one cycle, core released
module y86_mem_bridge
   import y86_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WORD_W-1:0]  cpu_addr,
   input  logic               cpu_re,
   input  logic               cpu_we,
   input  logic [WORD_W-1:0]  cpu_wdata,
   output logic [WORD_W-1:0]  cpu_rdata,
   output logic               cpu_stall,
   output logic               bus_err,
   y86_mem_bridge_if.master   mem
);

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t             state_q;
   logic               op_we_q;
   logic [1:0]         off_q;
   logic [WADDR_W-1:0] waddr_q;
   logic [WORD_W-1:0]  wdata_q;
   logic [WORD_W-1:0]  beat0_q;
   logic [7:0]         wait_q;
   logic [WORD_W-1:0]  rdata_q;
   logic               err_q;
   logic               mem_req_q;
   logic               mem_we_q;
   logic [3:0]         mem_be_q;
   logic [WADDR_W-1:0] mem_addr_q;
   logic [WORD_W-1:0]  mem_wdata_q;

   logic               cpu_req;
   logic [WORD_W-1:0]  wr_lo_data;
   logic [3:0]         wr_lo_be;
   logic [WORD_W-1:0]  wr_hi_data;
   logic [3:0]         wr_hi_be;
   logic [WORD_W-1:0]  rd_lo_src;
   logic [WORD_W-1:0]  rd_merge;
   logic [3:0]         rd_be;

   assign cpu_req = cpu_re | cpu_we;

   // First write beat is built straight from the core inputs so BEAT0 can
   // be issued on the same edge the request is latched.
   y86_byte_align u_wr_lo (
      .off_i     (cpu_addr[1:0]),
      .dir_i     (ALIGN_WR_LO),
      .data_lo_i (cpu_wdata),
      .data_hi_i ('0),
      .data_o    (wr_lo_data),
      .be_o      (wr_lo_be)
   );

   y86_byte_align u_wr_hi (
      .off_i     (off_q),
      .dir_i     (ALIGN_WR_HI),
      .data_lo_i (wdata_q),
      .data_hi_i ('0),
      .data_o    (wr_hi_data),
      .be_o      (wr_hi_be)
   );

   // In BEAT0 the only merge ever used is the aligned case (off=0), where
   // the result is the acked word itself.
   assign rd_lo_src = (state_q == BEAT1) ? beat0_q : mem.mem_rdata;

   y86_byte_align u_rd (
      .off_i     (off_q),
      .dir_i     (ALIGN_RD),
      .data_lo_i (rd_lo_src),
      .data_hi_i (mem.mem_rdata),
      .data_o    (rd_merge),
      .be_o      (rd_be)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         op_we_q     <= 1'b0;
         off_q       <= '0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         beat0_q     <= '0;
         wait_q      <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               rdata_q <= '0;
               if (cpu_req) begin
                  op_we_q     <= cpu_we;
                  off_q       <= cpu_addr[1:0];
                  waddr_q     <= cpu_addr[31:2];
                  wdata_q     <= cpu_wdata;
                  wait_q      <= '0;
                  if (cpu_re && cpu_we) err_q <= 1'b1;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= cpu_we;
                  mem_addr_q  <= cpu_addr[31:2];
                  mem_be_q    <= cpu_we ? wr_lo_be : rd_be;
                  mem_wdata_q <= cpu_we ? wr_lo_data : '0;
                  state_q     <= BEAT0;
               end
            end
            BEAT0, BEAT1: begin
               if (mem.mem_ack) begin
                  if (state_q == BEAT0) beat0_q <= mem.mem_rdata;
                  if (state_q == BEAT0 && off_q != 2'b00) begin
                     state_q     <= BEAT1;
                     wait_q      <= '0;
                     mem_addr_q  <= waddr_q + 30'd1;
                     mem_be_q    <= op_we_q ? wr_hi_be : rd_be;
                     mem_wdata_q <= op_we_q ? wr_hi_data : '0;
                  end else begin
                     state_q     <= DONE;
                     rdata_q     <= op_we_q ? '0 : rd_merge;
                     mem_req_q   <= 1'b0;
                     mem_we_q    <= 1'b0;
                     mem_be_q    <= '0;
                     mem_wdata_q <= '0;
                  end
               end else if (wait_q == WAIT_LAST) begin
                  // Timeout abandons any remaining beat.
                  state_q     <= DONE;
                  err_q       <= 1'b1;
                  rdata_q     <= TIMEOUT_RDATA;
                  mem_req_q   <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_be_q    <= '0;
                  mem_wdata_q <= '0;
               end else begin
                  wait_q <= wait_q + 8'd1;
               end
            end
            DONE: begin
               rdata_q <= '0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Request acceptance stalls the core combinationally; held in reset the
   // bridge accepts nothing, so no stall either.
   assign cpu_stall = rst && ((state_q == IDLE && cpu_req) ||
                              state_q == BEAT0 || state_q == BEAT1);

   assign cpu_rdata     = rdata_q;
   assign bus_err       = err_q;
   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_be    = mem_be_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;

endmodule
